// File: rtl/otter_intc_pkg.sv
// rtl/otter_intc_pkg.sv - shared state encoding and register map for the OTTER interrupt controller
package otter_intc_pkg;

  // Controller sequencing: wait for a request, hold intrpt until ACK, then wait for COMPLETE
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Byte offsets from BASE_ADDR; only addr[3:2] are decoded
  localparam logic [3:0] OFF_PENDING  = 4'h0;
  localparam logic [3:0] OFF_ENABLE   = 4'h4;
  localparam logic [3:0] OFF_ACK      = 4'h8;
  localparam logic [3:0] OFF_COMPLETE = 4'hC;

  // Position of the valid flag in the ACK read word
  localparam int VALID_BIT = 31;

endpackage

// File: rtl/otter_intc_prio.sv
// rtl/otter_intc_prio.sv - lowest-index-wins priority encoder over pending & enable
module otter_intc_prio
  import otter_intc_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [4:0]         best_id,
  output logic               valid
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    best_id = '0;
    valid   = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        best_id = 5'(i);
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/otter_intc.sv
// rtl/otter_intc.sv - MMIO interrupt controller top; OTTER_INTC_SYNC_EN adds 2-flop source synchronizers
module otter_intc
  import otter_intc_pkg::*;
#(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        iobus_addr,
  input  logic [31:0]        iobus_out,
  input  logic               iobus_wr,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic [31:0]        rd_data,
  output logic               rd_hit,
  output logic               intrpt
);

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] src_in;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] w1c_mask;
  logic [NUM_SRC-1:0] ack_mask;
  logic [4:0]         claim_id;
  logic [4:0]         best_id;
  logic [4:0]         wr_id;
  logic               best_valid;
  logic               hit;
  logic [3:0]         offset;
  logic               wr_pending;
  logic               wr_enable;
  logic               wr_ack;
  logic               wr_complete;
  logic               ack_ok;
  logic               complete_ok;
  state_t             state;
  state_t             state_next;
  logic               unused_bits;

  assign hit    = (iobus_addr[31:4] == BASE_ADDR[31:4]);
  assign offset = {iobus_addr[3:2], 2'b00};
  assign wr_id  = iobus_out[4:0];

  assign wr_pending  = iobus_wr & hit & (offset == OFF_PENDING);
  assign wr_enable   = iobus_wr & hit & (offset == OFF_ENABLE);
  assign wr_ack      = iobus_wr & hit & (offset == OFF_ACK);
  assign wr_complete = iobus_wr & hit & (offset == OFF_COMPLETE);

  // best_id is always below NUM_SRC when valid, so out-of-range ids never match
  assign ack_ok      = wr_ack & (state == ASSERT) & best_valid & (wr_id == best_id);
  assign complete_ok = wr_complete & (state == SERVICE) & (wr_id == claim_id);

`ifdef OTTER_INTC_SYNC_EN
  logic [NUM_SRC-1:0] sync_1;
  logic [NUM_SRC-1:0] sync_2;

  // Two-stage synchronizer for asynchronous sources
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= irq_src;
      sync_2 <= sync_1;
    end
  end

  assign src_in = sync_2;
`else
  assign src_in = irq_src;
`endif

  assign rise     = src_in & ~src_q;
  assign active   = pending & enable;
  assign w1c_mask = wr_pending ? iobus_out[NUM_SRC-1:0] : '0;
  assign ack_mask = ack_ok ? (NUM_SRC'(1) << best_id) : '0;

  otter_intc_prio #(
    .NUM_SRC (NUM_SRC)
  ) u_prio (
    .req     (active),
    .best_id (best_id),
    .valid   (best_valid)
  );

  // Pending, enable, edge history and claim registers; a rise beats any clear on the same bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      enable   <= '0;
      src_q    <= '0;
      claim_id <= '0;
    end else begin
      src_q   <= src_in;
      pending <= (pending & ~w1c_mask & ~ack_mask) | rise;
      if (wr_enable) begin
        enable <= iobus_out[NUM_SRC-1:0];
      end
      if (ack_ok) begin
        claim_id <= wr_id;
      end
    end
  end

  // State register; intrpt is registered from the next state so it tracks ASSERT exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      intrpt <= 1'b0;
    end else begin
      state  <= state_next;
      intrpt <= (state_next == ASSERT);
    end
  end

  // Next-state logic: one interrupt in flight, no preemption
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (|active) state_next = ASSERT;
      end
      ASSERT: begin
        if (ack_ok)        state_next = SERVICE;
        else if (!(|active)) state_next = IDLE;
      end
      SERVICE: begin
        if (complete_ok) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Side-effect-free register readback, zero outside the window
  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (offset)
        OFF_PENDING:  rd_data = 32'(pending);
        OFF_ENABLE:   rd_data = 32'(enable);
        OFF_ACK: begin
          rd_data[VALID_BIT] = best_valid;
          rd_data[4:0]       = best_id;
        end
        OFF_COMPLETE: rd_data = {29'b0, state, intrpt};
        default:      rd_data = '0;
      endcase
    end
  end

  assign rd_hit = hit;

  // Address byte lanes and upper data bits carry no meaning for this block
  assign unused_bits = ^{iobus_addr[1:0], iobus_out};

endmodule

// File: tb/tb_otter_intc.sv
// tb/tb_otter_intc.sv - directed and randomized self-checking bench for otter_intc
module tb_otter_intc;

  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'hFFFF0100;
`ifdef OTTER_INTC_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   iobus_addr;
  logic [31:0]   iobus_out;
  logic          iobus_wr;
  logic [N-1:0]  irq_src;
  logic [31:0]   rd_data;
  logic          rd_hit;
  logic          intrpt;

  int tests  = 0;
  int failed = 0;

  // Reference model state
  bit           m_pend[N];
  bit           m_en[N];
  logic [N-1:0] m_srcq;
  logic [N-1:0] m_s1;
  logic [N-1:0] m_s2;
  int           m_state;
  int           m_claim;
  bit           m_intr;

  otter_intc #(
    .NUM_SRC   (N),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iobus_addr (iobus_addr),
    .iobus_out  (iobus_out),
    .iobus_wr   (iobus_wr),
    .irq_src    (irq_src),
    .rd_data    (rd_data),
    .rd_hit     (rd_hit),
    .intrpt     (intrpt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int best();
    for (int k = 0; k < N; k++) if (m_pend[k] && m_en[k]) return k;
    return -1;
  endfunction

  function automatic logic [31:0] pend_word();
    logic [31:0] w = '0;
    for (int k = 0; k < N; k++) w[k] = m_pend[k];
    return w;
  endfunction

  function automatic logic [31:0] en_word();
    logic [31:0] w = '0;
    for (int k = 0; k < N; k++) w[k] = m_en[k];
    return w;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_pend[k] = 1'b0;
      m_en[k]   = 1'b0;
    end
    m_srcq  = '0;
    m_s1    = '0;
    m_s2    = '0;
    m_state = 0;
    m_claim = 0;
    m_intr  = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    bit           in_win = (iobus_addr[31:4] == BASE[31:4]);
    int           off    = int'(iobus_addr[3:2]);
    int           id     = int'(iobus_out[4:0]);
    bit           wr     = iobus_wr && in_win;
    int           b      = best();
    bit           ack_ok;
    int           ns     = m_state;
    logic [N-1:0] src_in;
    bit           newp[N];
`ifdef OTTER_INTC_SYNC_EN
    src_in = m_s2;
    m_s2   = m_s1;
    m_s1   = irq_src;
`else
    src_in = irq_src;
`endif
    ack_ok = wr && off == 2 && m_state == 1 && b >= 0 && id == b;
    for (int k = 0; k < N; k++) begin
      newp[k] = m_pend[k];
      if (wr && off == 0 && iobus_out[k]) newp[k] = 1'b0;
      if (ack_ok && k == b) newp[k] = 1'b0;
      if (src_in[k] && !m_srcq[k]) newp[k] = 1'b1;
    end
    if (m_state == 0) begin
      if (b >= 0) ns = 1;
    end else if (m_state == 1) begin
      if (ack_ok) begin
        ns      = 2;
        m_claim = id;
      end else if (b < 0) ns = 0;
    end else begin
      if (wr && off == 3 && id == m_claim) ns = 0;
    end
    for (int k = 0; k < N; k++) begin
      m_pend[k] = newp[k];
      if (wr && off == 1) m_en[k] = iobus_out[k];
    end
    m_state = ns;
    m_intr  = (ns == 1);
    m_srcq  = src_in;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] off, output logic [31:0] v);
    iobus_addr = BASE + 32'(off);
    #1;
    v = rd_data;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    iobus_addr = BASE + 32'(off);
    iobus_out  = d;
    iobus_wr   = 1'b1;
    tick();
    iobus_wr   = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] mask);
    irq_src = mask;
    tick();
    irq_src = '0;
    repeat (EXTRA) tick();
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    int          b = best();
    chk({tag, "/intrpt"}, 32'(intrpt), 32'(m_intr));
    rd(4'h0, v);
    chk({tag, "/pending"}, v, pend_word());
    chk({tag, "/hit"}, 32'(rd_hit), 32'd1);
    rd(4'h4, v);
    chk({tag, "/enable"}, v, en_word());
    rd(4'h8, v);
    chk({tag, "/ack"}, v, (b >= 0) ? {1'b1, 26'b0, 5'(b)} : 32'h0);
    rd(4'hC, v);
    chk({tag, "/complete"}, v, {29'b0, 2'(m_state), m_intr});
    iobus_addr = BASE + 32'h10;
    #1;
    chk({tag, "/miss_hit"}, 32'(rd_hit), 32'd0);
    chk({tag, "/miss_data"}, rd_data, 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    int          b;
    int          op;
    rst_n      = 1'b0;
    iobus_addr = '0;
    iobus_out  = '0;
    iobus_wr   = 1'b0;
    irq_src    = '0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single source, enable 0x05, source 2
    wr(4'h4, 32'h05);
    pulse(8'h04);
    rd(4'h0, v);  chk("t1_pending", v, 32'h04);
    rd(4'h8, v);  chk("t1_ack", v, 32'h80000002);
    chk("t1_intrpt_pre", 32'(intrpt), 32'd0);
    tick();
    chk("t1_intrpt", 32'(intrpt), 32'd1);
    check_all("t1");

    // Ack, bad complete, good complete
    wr(4'h8, 32'd2);
    chk("t2_intrpt", 32'(intrpt), 32'd0);
    rd(4'h0, v);  chk("t2_pending", v, 32'h0);
    rd(4'hC, v);  chk("t2_service", v, 32'h4);
    wr(4'hC, 32'd1);
    rd(4'hC, v);  chk("t2_bad_complete", v, 32'h4);
    wr(4'hC, 32'd2);
    rd(4'hC, v);  chk("t2_idle", v, 32'h0);
    check_all("t2");

    // Two sources at once, lowest id first, then re-arm
    pulse(8'h05);
    rd(4'h8, v);  chk("t3_ack0", v, 32'h80000000);
    tick();
    wr(4'h8, 32'd0);
    wr(4'hC, 32'd0);
    rd(4'h8, v);  chk("t3_ack2", v, 32'h80000002);
    tick();
    chk("t3_rearm", 32'(intrpt), 32'd1);
    wr(4'h8, 32'd2);
    wr(4'hC, 32'd2);
    check_all("t3");

    // Disabled source, late enable, withdraw by W1C
    wr(4'h4, 32'h0);
    pulse(8'h08);
    tick();
    chk("t4_masked", 32'(intrpt), 32'd0);
    wr(4'h4, 32'h08);
    tick();
    chk("t4_enabled", 32'(intrpt), 32'd1);
    wr(4'h0, 32'h08);
    tick();
    chk("t4_withdrawn", 32'(intrpt), 32'd0);
    check_all("t4");

`ifndef OTTER_INTC_SYNC_EN
    // Rise and W1C on the same bit in the same cycle: set wins
    irq_src    = 8'h02;
    iobus_addr = BASE;
    iobus_out  = 32'h02;
    iobus_wr   = 1'b1;
    tick();
    iobus_wr   = 1'b0;
    irq_src    = '0;
    rd(4'h0, v);  chk("t5_set_wins", v, 32'h02);
    check_all("t5");
`endif

    // Enter SERVICE then reset asynchronously
    wr(4'h0, 32'hFF);
    wr(4'h4, 32'h02);
    pulse(8'h02);
    tick();
    wr(4'h8, 32'd1);
    rd(4'hC, v);  chk("t6_service", v, 32'h4);
    check_all("t6");
    rst_n = 1'b0;
    #1;
    chk("t6_rst_intrpt", 32'(intrpt), 32'd0);
    rd(4'h0, v);  chk("t6_rst_pending", v, 32'h0);
    rd(4'h4, v);  chk("t6_rst_enable", v, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    check_all("t6_after");

    // Randomized traffic against the model
    for (int c = 0; c < 300; c++) begin
      b          = best();
      op         = int'($urandom_range(0, 9));
      irq_src    = N'($urandom & $urandom & $urandom);
      iobus_addr = BASE + 32'h10;
      iobus_out  = $urandom;
      iobus_wr   = 1'b0;
      case (op)
        0: begin iobus_addr = BASE + 32'h4; iobus_wr = 1'b1; end
        1: begin iobus_addr = BASE;         iobus_wr = 1'b1; iobus_out = $urandom & $urandom; end
        2, 3: begin
          iobus_addr = BASE + 32'h8;
          iobus_wr   = 1'b1;
          iobus_out  = (b >= 0 && $urandom_range(0, 3) != 0) ? 32'(b) : 32'($urandom_range(0, 31));
        end
        4: begin
          iobus_addr = BASE + 32'hC;
          iobus_wr   = 1'b1;
          iobus_out  = ($urandom_range(0, 3) != 0) ? 32'(m_claim) : 32'($urandom_range(0, 31));
        end
        5: begin
          iobus_addr = ($urandom_range(0, 1) != 0) ? BASE + 32'h10 + 32'($urandom_range(0, 3) * 4)
                                                   : BASE - 32'h4;
          iobus_wr   = 1'b1;
        end
        default: ;
      endcase
      tick();
      iobus_wr = 1'b0;
      check_all($sformatf("rnd%0d", c));
    end

    // Source-to-pending latency
    irq_src = '0;
    wr(4'h0, 32'hFF);
    repeat (3) tick();
    wr(4'h0, 32'hFF);
    irq_src = 8'h80;
    tick();
`ifdef OTTER_INTC_SYNC_EN
    irq_src = '0;
    rd(4'h0, v);  chk("lat_c1", v & 32'h80, 32'h0);
    tick();
    rd(4'h0, v);  chk("lat_c2", v & 32'h80, 32'h0);
    tick();
    rd(4'h0, v);  chk("lat_c3", v & 32'h80, 32'h80);
`else
    irq_src = '0;
    rd(4'h0, v);  chk("lat_c1", v & 32'h80, 32'h80);
`endif
    check_all("lat");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/otter_intc.md
Name: otter_intc

Overview:
- Memory-mapped interrupt controller on the OTTER SoC iobus.
- Collects up to NUM_SRC external interrupt sources and latches rising edges into pending bits. Applies per-source enables.
- Drives the single `intrpt` line into the OTTER core and sequences each interrupt through ack and complete over the iobus, so firmware services one source at a time.
- Sits beside the other MMIO peripherals. The SoC top muxes `rd_data` onto `iobus_in` when `rd_hit` is high.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..31).
- BASE_ADDR, 32'hFFFF0100, byte address of register 0; the block decodes a 16-byte window.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iobus_addr  in  32  CPU MMIO address.
- iobus_out  in  32  CPU MMIO write data.
- iobus_wr  in  1  CPU MMIO write strobe, one cycle per store.
- irq_src  in  NUM_SRC  raw interrupt sources, rising-edge sensitive.
- rd_data  out  32  register read data, combinational from address.
- rd_hit  out  1  iobus_addr lies inside the window.
- intrpt  out  1  interrupt request to the core, registered.

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0:
  - pending, enable, src_q, claim_id, state cleared to 0; state = IDLE.
  - intrpt=0.
  - rd_data and rd_hit follow the address decode only.
- Edge detect: src_q is irq_src registered. rise = irq_src & ~src_q. A rise sets its pending bit at the next edge, regardless of enable.
- Register map (offset from BASE_ADDR; word aligned, addr[1:0] ignored):
  - 0x0 PENDING: R = pending. W = write-1-to-clear.
  - 0x4 ENABLE: R/W, bits [NUM_SRC-1:0]; upper bits read 0.
  - 0x8 ACK: R = {valid, 26'b0, best_id[4:0]}, where best_id is the lowest-index set bit of pending & enable. W = acknowledge the id in data[4:0].
  - 0xC COMPLETE: R = {29'b0, state[1:0], intrpt}. W = complete the id in data[4:0].
- Write visibility: writes take effect at the clock edge where iobus_wr=1 and the address hits. Reads are combinational and have no side effects.
- Simultaneous set/clear: if a rise and a W1C hit the same bit in one cycle, set wins and the bit stays 1.
- State machine (2-bit):
  - IDLE, intrpt=0: if any bit of pending & enable is set, go to ASSERT. intrpt rises on the edge that enters ASSERT, giving 1-cycle latency from a visible pending bit.
  - ASSERT, intrpt=1: on an ACK write whose id equals best_id and whose valid is set:
    - claim_id <= id;
    - that pending bit is cleared;
    - go to SERVICE; intrpt falls on the same edge.
    - An ACK with a mismatched id is ignored and the state stays ASSERT.
    - If pending & enable becomes 0 (W1C or disable) before the ACK, return to IDLE and drop intrpt.
  - SERVICE, intrpt=0: on a COMPLETE write whose id equals claim_id, go to IDLE. Any other COMPLETE is ignored. New rises still latch into pending. There is no preemption.
- Re-arm: IDLE re-evaluates pending & enable every cycle, so back-to-back interrupts assert again 1 cycle after COMPLETE.
- Ids ≥ NUM_SRC are never valid, so ACK and COMPLETE writes carrying them are ignored.
- Writes outside the window are ignored. rd_hit=0 there and rd_data=0.

Optional Feature:
- Macro: OTTER_INTC_SYNC_EN.
- Defined: each irq_src bit passes through a 2-flop synchronizer (reset to 0) before the edge detector. Source-to-pending latency is 3 cycles.
- Undefined: irq_src feeds the edge detector directly. Latency is 1 cycle; sources must already be synchronous to clk.

Decomposition:
- Package otter_intc_pkg holds:
  - the state enum (IDLE=0, ASSERT=1, SERVICE=2);
  - register offset constants (OFF_PENDING, OFF_ENABLE, OFF_ACK, OFF_COMPLETE);
  - the bit-31 valid position.
- Sub-module otter_intc_prio: combinational lowest-index priority encoder. Takes pending & enable; returns best_id and valid.

Test Plan:
- Reset then program ENABLE=0x05; pulse irq_src[2] → PENDING reads 0x04, ACK reads 0x80000002, intrpt=1 one cycle later.
- In ASSERT write ACK=2 → intrpt=0 next cycle, PENDING=0x00, COMPLETE reads state=2. Write COMPLETE=1 → ignored. Write COMPLETE=2 → state=IDLE.
- Pulse sources 0 and 2 in the same cycle, ENABLE=0x05 → ACK reads id 0. After ack/complete of 0, intrpt re-asserts with id 2.
- Source 3 pending with ENABLE=0 → intrpt stays 0. Set ENABLE=0x08 → intrpt=1. Clear via W1C PENDING=0x08 before ACK → back to IDLE, intrpt=0.
- Rise on source 1 in the same cycle as W1C PENDING=0x02 → bit 1 remains set.
- Drive rst_n=0 mid-SERVICE → intrpt=0, PENDING=0, ENABLE=0 immediately, without waiting for a clock edge. With OTTER_INTC_SYNC_EN defined, check the 3-cycle source-to-pending latency.
